// File: rtl/smd_pad_pkg.sv
// Shared constants and helpers for the Mega Drive pad encoder.
// Pin indices address the packed output vector {p1,p2,p3,p4,p6,p9}.
package smd_pad_pkg;

    localparam int P1 = 5;
    localparam int P2 = 4;
    localparam int P3 = 3;
    localparam int P4 = 2;
    localparam int P6 = 1;
    localparam int P9 = 0;

    localparam logic [2:0] FC_0 = 3'd0;
    localparam logic [2:0] FC_1 = 3'd1;
    localparam logic [2:0] FC_2 = 3'd2;
    localparam logic [2:0] FC_3 = 3'd3;
    localparam logic [2:0] FC_4 = 3'd4;

    // Active-low button set as held for a burst; Home is already folded into md.
    typedef struct packed {
        logic up;
        logic dw;
        logic lf;
        logic rg;
        logic a;
        logic b;
        logic c;
        logic st;
        logic x;
        logic y;
        logic z;
        logic md;
    } btn_t;

    function automatic int calc_timeout_cyc(input int clk_hz, input int timeout_us);
        return (clk_hz / 1000000) * timeout_us;
    endfunction

endpackage

// File: rtl/smd_th_filter.sv
// TH select conditioning: 2-FF synchroniser, level deglitch and edge pulses.
// th_fall/th_rise are asserted in the cycle before th_lvl takes the new level.
module smd_th_filter
    import smd_pad_pkg::*;
#(
    parameter int FILT_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic p7,
    output logic th_lvl,
    output logic th_fall,
    output logic th_rise
);

    localparam int CW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          lvl_r;
    logic [CW-1:0] cnt_r;
    logic          accept_s;

    // A differing level is accepted once it has been seen FILT_CYC samples in a row.
    always_comb begin
        accept_s = 1'b0;
        if ((sync2_r != lvl_r) && (cnt_r == CNT_LAST)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Synchroniser, run-length counter and accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            lvl_r   <= 1'b1;
            cnt_r   <= '0;
        end else begin
            sync1_r <= p7;
            sync2_r <= sync1_r;
            if (sync2_r == lvl_r) begin
                cnt_r <= '0;
            end else if (accept_s) begin
                lvl_r <= sync2_r;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign th_lvl  = lvl_r;
    assign th_fall = accept_s & ~sync2_r;
    assign th_rise = accept_s & sync2_r;

endmodule

// File: rtl/smd_pad_encoder.sv
// Mega Drive pad encoder: phase counter, idle timer, burst snapshot and
// registered DB9 pin mux driven by the filtered TH select line.
module smd_pad_encoder
    import smd_pad_pkg::*;
#(
    parameter int CLK_HZ     = 10_000_000,
    parameter int TIMEOUT_US = 1500,
    parameter int FILT_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p7,
    input  logic       six_en,
    input  logic       up,
    input  logic       dw,
    input  logic       lf,
    input  logic       rg,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       st,
    input  logic       x,
    input  logic       y,
    input  logic       z,
    input  logic       md,
    input  logic       hm,
    output logic [5:0] p
);

    localparam int TIMEOUT_CYC = calc_timeout_cyc(CLK_HZ, TIMEOUT_US);
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC);

    logic          th_lvl_s;
    logic          th_fall_s;
    logic          th_rise_s;
    logic [2:0]    fc_r;
    logic [2:0]    fc_nxt_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic          mode_r;
    logic          mode_nxt_s;
    logic          snap_load_s;
    btn_t          live_s;
    btn_t          snap_r;
    btn_t          src_s;
    logic [5:0]    p_nxt_s;
    logic [5:0]    p_r;

    smd_th_filter #(
        .FILT_CYC (FILT_CYC)
    ) u_th_filter (
        .clk     (clk),
        .rst     (rst),
        .p7      (p7),
        .th_lvl  (th_lvl_s),
        .th_fall (th_fall_s),
        .th_rise (th_rise_s)
    );

    assign live_s = {up, dw, lf, rg, a, b, c, st, x, y, z, (md & hm)};

    // Phase state: fall count, idle timer and latched protocol mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_r    <= FC_0;
            timer_r <= '0;
            mode_r  <= six_en;
        end else begin
            fc_r    <= fc_nxt_s;
            timer_r <= timer_nxt_s;
            mode_r  <= mode_nxt_s;
        end
    end

    // Next phase: an accepted edge always beats a coinciding timeout.
    always_comb begin
        fc_nxt_s    = fc_r;
        timer_nxt_s = timer_r;
        mode_nxt_s  = mode_r;
        snap_load_s = 1'b0;
        if (fc_r == FC_0) begin
            mode_nxt_s = six_en;
        end else begin
            mode_nxt_s = mode_r;
        end
        if (th_fall_s || th_rise_s) begin
            timer_nxt_s = '0;
            if (th_fall_s) begin
                case (fc_r)
                    FC_0: begin
                        fc_nxt_s    = FC_1;
                        snap_load_s = 1'b1;
                    end
                    FC_1:    fc_nxt_s = FC_2;
                    FC_2:    fc_nxt_s = mode_r ? FC_3 : FC_2;
                    FC_3:    fc_nxt_s = FC_4;
                    FC_4:    fc_nxt_s = FC_4;
                    default: fc_nxt_s = FC_0;
                endcase
            end else begin
                fc_nxt_s = fc_r;
            end
        end else if (timer_r == TIMEOUT_MAX) begin
            fc_nxt_s    = FC_0;
            timer_nxt_s = timer_r;
        end else begin
            fc_nxt_s    = fc_r;
            timer_nxt_s = timer_r + TW'(1);
        end
    end

    // Burst snapshot, captured on the fall that opens a burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_r <= '1;
        end else if (snap_load_s) begin
            snap_r <= live_s;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Pin mux from the current phase and filtered TH level.
    always_comb begin
        p_nxt_s = 6'b111111;
        if (fc_r == FC_0) begin
            src_s = live_s;
        end else begin
            src_s = snap_r;
        end
        p_nxt_s[P6] = th_lvl_s ? src_s.b : src_s.a;
        p_nxt_s[P9] = th_lvl_s ? src_s.c : src_s.st;
        case (fc_r)
            FC_0, FC_1, FC_2: begin
                p_nxt_s[P1] = src_s.up;
                p_nxt_s[P2] = src_s.dw;
                p_nxt_s[P3] = th_lvl_s ? src_s.lf : 1'b0;
                p_nxt_s[P4] = th_lvl_s ? src_s.rg : 1'b0;
            end
            FC_3: begin
                p_nxt_s[P1] = th_lvl_s ? src_s.z  : 1'b0;
                p_nxt_s[P2] = th_lvl_s ? src_s.y  : 1'b0;
                p_nxt_s[P3] = th_lvl_s ? src_s.x  : 1'b0;
                p_nxt_s[P4] = th_lvl_s ? src_s.md : 1'b0;
            end
            FC_4: begin
                p_nxt_s[P1] = th_lvl_s ? src_s.up : 1'b1;
                p_nxt_s[P2] = th_lvl_s ? src_s.dw : 1'b1;
                p_nxt_s[P3] = th_lvl_s ? src_s.lf : 1'b1;
                p_nxt_s[P4] = th_lvl_s ? src_s.rg : 1'b1;
            end
            default: begin
                p_nxt_s = 6'b111111;
            end
        endcase
    end

    // Registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r <= 6'b111111;
        end else begin
            p_r <= p_nxt_s;
        end
    end

    assign p = p_r;

endmodule

// File: tb/tb_smd_pad_encoder.sv
// Directed bench for smd_pad_encoder at default parameters (10 MHz, 15000-cycle timeout).
module tb_smd_pad_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p7 = 1'b1;
    logic       six_en = 1'b1;
    logic       up = 1'b0, dw = 1'b1, lf = 1'b1, rg = 1'b1;
    logic       a = 1'b1, b = 1'b1, c = 1'b1, st = 1'b1;
    logic       x = 1'b1, y = 1'b0, z = 1'b1, md = 1'b1, hm = 1'b1;
    logic [5:0] p;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    smd_pad_encoder dut (
        .clk    (clk),
        .rst    (rst),
        .p7     (p7),
        .six_en (six_en),
        .up     (up),
        .dw     (dw),
        .lf     (lf),
        .rg     (rg),
        .a      (a),
        .b      (b),
        .c      (c),
        .st     (st),
        .x      (x),
        .y      (y),
        .z      (z),
        .md     (md),
        .hm     (hm),
        .p      (p)
    );

    task automatic chk(input logic [5:0] exp, input string tag);
        tests++;
        assert (p === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, p, exp);
        end
    endtask

    // Change p7, check p once the 5-cycle latency has elapsed, then hold to 130 cycles.
    task automatic drive_th(input logic v, input logic [5:0] exp, input string tag);
        @(negedge clk);
        p7 = v;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk(exp, tag);
        repeat (125) @(posedge clk);
    endtask

    task automatic do_reset(input logic [5:0] exp_after, input string tag);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(6'b111111, {tag, "_during"});
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(exp_after, {tag, "_after"});
    endtask

    task automatic six_burst(input string tag);
        drive_th(1'b0, 6'b010011, {tag, "_l1"});
        drive_th(1'b1, 6'b011111, {tag, "_h1"});
        drive_th(1'b0, 6'b010011, {tag, "_l2"});
        drive_th(1'b1, 6'b011111, {tag, "_h2"});
        drive_th(1'b0, 6'b000011, {tag, "_l3"});
        drive_th(1'b1, 6'b101111, {tag, "_h3"});
        drive_th(1'b0, 6'b111111, {tag, "_l4"});
        drive_th(1'b1, 6'b011111, {tag, "_h4"});
    endtask

    initial begin
        // 1: reset with up and y pressed
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(6'b111111, "rst_hold");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(6'b011111, "rst_release");

        // 2: six-button burst, first fall also checks latency
        @(negedge clk);
        p7 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(6'b011111, "lat_4cyc");
        @(posedge clk);
        @(negedge clk);
        chk(6'b010011, "lat_5cyc");
        repeat (124) @(posedge clk);
        drive_th(1'b1, 6'b011111, "b1_h1");
        drive_th(1'b0, 6'b010011, "b1_l2");
        drive_th(1'b1, 6'b011111, "b1_h2");
        drive_th(1'b0, 6'b000011, "b1_l3");
        drive_th(1'b1, 6'b101111, "b1_h3");
        drive_th(1'b0, 6'b111111, "b1_l4");
        drive_th(1'b1, 6'b011111, "b1_h4");

        // 3a: idle past the timeout, burst restarts
        repeat (15000) @(posedge clk);
        six_burst("b2");

        // 3b: gap just short of the timeout keeps fc saturated at 4
        repeat (14990 - 130) @(posedge clk);
        drive_th(1'b0, 6'b111111, "gap_l");
        drive_th(1'b1, 6'b011111, "gap_h");

        // 4: three-button mode never reaches ID or extended phases
        six_en = 1'b0;
        do_reset(6'b011111, "rst3b");
        drive_th(1'b0, 6'b010011, "b3_l1");
        drive_th(1'b1, 6'b011111, "b3_h1");
        drive_th(1'b0, 6'b010011, "b3_l2");
        drive_th(1'b1, 6'b011111, "b3_h2");
        drive_th(1'b0, 6'b010011, "b3_l3");
        drive_th(1'b1, 6'b011111, "b3_h3");
        drive_th(1'b0, 6'b010011, "b3_l4");
        drive_th(1'b1, 6'b011111, "b3_h4");

        // 5: 1-cycle glitch ignored; mid-burst button changes held off by snapshot
        six_en = 1'b1;
        do_reset(6'b011111, "rst6b");
        @(negedge clk);
        p7 = 1'b0;
        @(negedge clk);
        p7 = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk(6'b011111, "glitch_p");
        drive_th(1'b0, 6'b010011, "g_l1");
        drive_th(1'b1, 6'b011111, "g_h1");
        a = 1'b0;
        x = 1'b0;
        drive_th(1'b0, 6'b010011, "g_l2_snapA");
        drive_th(1'b1, 6'b011111, "g_h2");
        drive_th(1'b0, 6'b000011, "g_l3_id");
        drive_th(1'b1, 6'b101111, "g_h3_snapX");
        a = 1'b1;
        x = 1'b1;

        // 6: Home reports as Mode; reset mid-burst at fc=3
        hm = 1'b0;
        do_reset(6'b011111, "rst_hm");
        drive_th(1'b0, 6'b010011, "hm_l1");
        drive_th(1'b1, 6'b011111, "hm_h1");
        drive_th(1'b0, 6'b010011, "hm_l2");
        drive_th(1'b1, 6'b011111, "hm_h2");
        drive_th(1'b0, 6'b000011, "hm_l3");
        drive_th(1'b1, 6'b101011, "hm_h3_md");
        do_reset(6'b011111, "rst_mid");
        drive_th(1'b0, 6'b010011, "mid_l1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
